// File: rtl/servant_arb_pkg.sv
// =============================================================================
// Module : servant_arb_pkg
// Brief  : Shared encodings for the servant RAM round-robin arbiter.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

package servant_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  localparam logic [1:0]  OWN_NONE    = 2'd0;
  localparam logic [1:0]  OWN_IB      = 2'd1;
  localparam logic [1:0]  OWN_DB      = 2'd2;
  localparam logic [1:0]  OWN_DM      = 2'd3;

  localparam logic [31:0] TIMEOUT_RDT = 32'hDEADBEEF;

  // Grant vector bit order is {dm, db, ib}.
  function automatic logic [1:0] onehot_to_owner(input logic [2:0] grant);
    logic [1:0] own;
    own = OWN_NONE;
    if (grant[0])      own = OWN_IB;
    else if (grant[1]) own = OWN_DB;
    else if (grant[2]) own = OWN_DM;
    return own;
  endfunction

endpackage

`default_nettype wire

// File: rtl/servant_rr_pick.sv
// =============================================================================
// Module : servant_rr_pick
// Brief  : Combinational 3-way round-robin picker, search starts after i_last.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module servant_rr_pick
  import servant_arb_pkg::*;
(
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [2:0] o_grant
);

  always_comb begin
    o_grant = 3'b000;
    case (i_last)
      OWN_IB: begin
        if (i_req[1])      o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
      end
      OWN_DB: begin
        if (i_req[2])      o_grant = 3'b100;
        else if (i_req[0]) o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
      end
      default: begin
        // OWN_DM (and the unused OWN_NONE) restart the search at ib.
        if (i_req[0])      o_grant = 3'b001;
        else if (i_req[1]) o_grant = 3'b010;
        else if (i_req[2]) o_grant = 3'b100;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/servant_ram_arbiter.sv
// =============================================================================
// Module : servant_ram_arbiter
// Brief  : Round-robin Wishbone arbiter (ibus/dbus/debug) for the servant RAM.
//          Optional watchdog: define SERVANT_RAM_ARBITER_TIMEOUT_EN.
// Rev    : 1.0 - initial release
// =============================================================================
`default_nettype none

module servant_ram_arbiter
  import servant_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rstn,

  input  logic [AW-1:0] i_ib_adr,
  input  logic          i_ib_cyc,
  output logic [31:0]   o_ib_rdt,
  output logic          o_ib_ack,

  input  logic [AW-1:0] i_db_adr,
  input  logic [31:0]   i_db_dat,
  input  logic [3:0]    i_db_sel,
  input  logic          i_db_we,
  input  logic          i_db_cyc,
  output logic [31:0]   o_db_rdt,
  output logic          o_db_ack,

  input  logic [AW-1:0] i_dm_adr,
  input  logic [31:0]   i_dm_dat,
  input  logic [3:0]    i_dm_sel,
  input  logic          i_dm_we,
  input  logic          i_dm_cyc,
  output logic [31:0]   o_dm_rdt,
  output logic          o_dm_ack,

  output logic [AW-1:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,

  output logic [1:0]    o_owner,
  output logic          o_err
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("servant_ram_arbiter: TIMEOUT_CYCLES out of range 2..65535");
  end

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic [1:0] r_owner;
  logic [1:0] w_owner_nxt;
  logic [1:0] r_last;
  logic [1:0] w_last_nxt;

  logic [2:0] w_req;
  logic [2:0] w_grant;
  logic       w_busy;
  logic       w_own_cyc;
  logic       w_to;
  logic       w_ack;
  logic [31:0] w_rdt;

  assign w_req  = {i_dm_cyc, i_db_cyc, i_ib_cyc};
  assign w_busy = (r_state == ST_BUSY);

  servant_rr_pick u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  always_comb begin
    w_own_cyc = 1'b0;
    case (r_owner)
      OWN_IB:  w_own_cyc = i_ib_cyc;
      OWN_DB:  w_own_cyc = i_db_cyc;
      OWN_DM:  w_own_cyc = i_dm_cyc;
      default: w_own_cyc = 1'b0;
    endcase
  end

`ifdef SERVANT_RAM_ARBITER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;

  // A real ack in the expiry cycle wins over the watchdog.
  assign w_to = w_busy & w_own_cyc & ~i_s_ack & (r_cnt == TO_LAST);

  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      r_cnt <= 16'd0;
    end else if (!w_busy) begin
      r_cnt <= 16'd0;
    end else if (!i_s_ack) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`else
  assign w_to = 1'b0;
`endif

  assign w_ack = w_busy & (i_s_ack | w_to);
  assign w_rdt = w_to ? TIMEOUT_RDT : i_s_rdt;

  always_ff @(posedge wb_clk or negedge wb_rstn) begin
    if (!wb_rstn) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_last  <= OWN_DM;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = onehot_to_owner(w_grant);
        end
      end
      ST_BUSY: begin
        // Completion, abort and timeout all release the grant the same way.
        if (i_s_ack || !w_own_cyc || w_to) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = r_owner;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
      end
    endcase
  end

  always_comb begin
    o_s_adr = '0;
    o_s_dat = 32'd0;
    o_s_sel = 4'd0;
    o_s_we  = 1'b0;
    if (w_busy) begin
      case (r_owner)
        OWN_IB: begin
          o_s_adr = i_ib_adr;
          o_s_sel = 4'hF;
        end
        OWN_DB: begin
          o_s_adr = i_db_adr;
          o_s_dat = i_db_dat;
          o_s_sel = i_db_sel;
          o_s_we  = i_db_we;
        end
        OWN_DM: begin
          o_s_adr = i_dm_adr;
          o_s_dat = i_dm_dat;
          o_s_sel = i_dm_sel;
          o_s_we  = i_dm_we;
        end
        default: begin
          o_s_adr = '0;
        end
      endcase
    end
  end

  assign o_s_cyc  = w_busy & w_own_cyc & ~w_to;

  assign o_ib_ack = w_ack & (r_owner == OWN_IB);
  assign o_db_ack = w_ack & (r_owner == OWN_DB);
  assign o_dm_ack = w_ack & (r_owner == OWN_DM);

  assign o_ib_rdt = w_rdt;
  assign o_db_rdt = w_rdt;
  assign o_dm_rdt = w_rdt;

  assign o_owner  = r_owner;
  assign o_err    = w_to;

endmodule

`default_nettype wire

// File: doc/servant_ram_arbiter.md
Name: servant_ram_arbiter

Overview:
- Round-robin Wishbone arbiter sharing the single servant RAM slave port between three masters: CPU instruction bus, CPU data bus (RAM-routed side), and the debug-module system bus.
- Grants one master per transaction and holds the grant until slave ack or master abort.
- Sits between the CPU/debug bus mux and servant_ram.

Parameters:
- AW, 32, address width of all master and slave address ports.
- TIMEOUT_CYCLES, 255, busy cycles without ack before forced completion (used only with the optional feature); legal range 2..65535.

Ports:
- wb_clk  in  1  clock
- wb_rstn  in  1  reset, asynchronous assert, active-low
- i_ib_adr  in  AW  ibus address
- i_ib_cyc  in  1  ibus request (read-only master)
- o_ib_rdt  out  32  ibus read data
- o_ib_ack  out  1  ibus ack
- i_db_adr  in  AW  dbus address
- i_db_dat  in  32  dbus write data
- i_db_sel  in  4  dbus byte select
- i_db_we  in  1  dbus write enable
- i_db_cyc  in  1  dbus request
- o_db_rdt  out  32  dbus read data
- o_db_ack  out  1  dbus ack
- i_dm_adr, i_dm_dat, i_dm_sel, i_dm_we, i_dm_cyc  in  AW/32/4/1/1  debug sbus request
- o_dm_rdt  out  32  debug read data
- o_dm_ack  out  1  debug ack
- o_s_adr  out  AW  slave address
- o_s_dat  out  32  slave write data
- o_s_sel  out  4  slave byte select
- o_s_we  out  1  slave write enable
- o_s_cyc  out  1  slave request
- i_s_rdt  in  32  slave read data
- i_s_ack  in  1  slave ack
- o_owner  out  2  current grant: 0 none, 1 ib, 2 db, 3 dm
- o_err  out  1  one-cycle timeout pulse

Behaviour:
- State machine IDLE/BUSY. Reset: state IDLE, owner 0, last-served pointer = dm, timeout counter 0.
- Outputs during reset: all acks 0, o_s_cyc 0, o_err 0.
- IDLE, any cyc high: pick the first requester after the last-served one in the fixed order ib->db->dm->ib. Register the grant and enter BUSY on the next edge.
- IDLE, no cyc: remain IDLE.
- Request-to-slave latency is 1 cycle: a request sampled at edge N produces o_s_cyc high in cycle N+1.
- BUSY slave outputs: o_s_* are driven combinationally from the owner's inputs. o_s_cyc = owner's cyc. ib owner forces o_s_we = 0, o_s_sel = 4'hF, o_s_dat = 0.
- Outside BUSY: o_s_cyc = 0; other o_s_* are don't-care but held at 0.
- Read data: i_s_rdt is broadcast to all three rdt outputs. Only the owner's ack follows i_s_ack; non-owner acks are always 0.
- Completion: i_s_ack while BUSY:
  - ack passes to the owner in the same cycle;
  - next edge: IDLE, last-served = owner, owner = 0.
  - One dead cycle always separates transactions.
- Abort: owner drops cyc while BUSY with no ack → IDLE next edge, last-served updated, no ack emitted.
- i_s_ack while IDLE, or from an aborted cycle, is ignored: no master ack.
- Requesters not granted keep cyc high and wait; no starvation. Worst-case wait is two foreign transactions.
- Simultaneous ack and owner cyc drop in one cycle: treat as completion; the ack is delivered.
- Reset asserted mid-transaction: immediate return to reset state; o_s_cyc drops asynchronously.

Optional Feature:
- Macro: SERVANT_RAM_ARBITER_TIMEOUT_EN.
- With the macro:
  - a 16-bit counter clears on entering BUSY and increments each BUSY cycle without ack;
  - when it reaches TIMEOUT_CYCLES-1, the arbiter itself acks the owner with rdt = 32'hDEADBEEF (rdt muxed for that cycle only) and pulses o_err;
  - o_s_cyc drops that same cycle; next edge IDLE.
- Without the macro: BUSY waits indefinitely, o_err is tied 0, and no counter is synthesised.

Decomposition:
- Package servant_arb_pkg holds:
  - owner encodings OWN_NONE/IB/DB/DM;
  - state encodings;
  - TIMEOUT_RDT = 32'hDEADBEEF.
- One sub-module: servant_rr_pick, a combinational 3-way round-robin priority picker. Inputs: request vector and last-served. Output: one-hot grant.

Test Plan:
- Single request: ib cyc at adr 0x40, slave acks 2 cycles after o_s_cyc, rdt 0x12345678 → o_ib_ack one cycle, o_ib_rdt = 0x12345678, o_owner 1→0, o_db_ack/o_dm_ack = 0.
- Contention: ib, db, dm all assert cyc from reset, slave acks each in 1 cycle → grant order ib, db, dm, with one idle cycle between grants.
- Fairness: ib held continuously with dm requesting → grants alternate ib, dm, ib, dm; dm never waits more than one ib transaction.
- Write path: db write adr 0x100, dat 0xA5A5A5A5, sel 4'b0011 → o_s_we = 1, o_s_sel = 0011, o_s_dat = 0xA5A5A5A5 while owner = 2.
- Abort and reset: dm drops cyc after 1 BUSY cycle → IDLE, no ack; wb_rstn low mid-BUSY → o_s_cyc = 0 immediately, o_owner = 0.
- Timeout (macro defined, TIMEOUT_CYCLES = 8): slave never acks → on BUSY cycle 8, o_ib_ack = 1, o_ib_rdt = 0xDEADBEEF, o_err pulses once, o_s_cyc = 0; without the macro, still BUSY at cycle 100.
